// File: rtl/cdc_channel_arbiter.sv
// Round-robin arbiter: funnels NUM_CH sensor-domain result channels into one toggle-synchroniser issue path.
// Optional sticky overwrite detection is enabled with `define CDC_ARB_OVERRUN_EN (adds OVERRUN / OVERRUN_CLR).
module cdc_channel_arbiter #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 12,
  parameter  int HOLDOFF    = 8,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  input  logic [NUM_CH-1:0]            REQ_FLAG,
  input  logic [NUM_CH*DATA_WIDTH-1:0] REQ_DATA,
`ifdef CDC_ARB_OVERRUN_EN
  input  logic                         OVERRUN_CLR,
  output logic [NUM_CH-1:0]            OVERRUN,
`endif
  output logic                         ISSUE_FLAG,
  output logic [CH_W+DATA_WIDTH-1:0]   ISSUE_DATA,
  output logic [NUM_CH-1:0]            PENDING,
  output logic                         BUSY
);

  localparam int CNT_W = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t                       state_reg, state_next;
  logic [NUM_CH-1:0]            pending_reg, pending_next;
  logic [CH_W-1:0]              last_grant_reg, last_grant_next;
  logic                         issue_flag_reg, issue_flag_next;
  logic [CH_W+DATA_WIDTH-1:0]   issue_data_reg, issue_data_next;
  logic [CNT_W-1:0]             cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0]        data_buf_reg [NUM_CH];
  logic [DATA_WIDTH-1:0]        req_data_arr [NUM_CH];
  logic [CH_W-1:0]              grant_idx;
  logic [CH_W-1:0]              search_idx;
  logic                         grant_found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_slice
      assign req_data_arr[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Latest value wins; capture runs in every state, independent of arbitration.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < NUM_CH; i++) data_buf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (REQ_FLAG[i]) data_buf_reg[i] <= req_data_arr[i];
      end
    end
  end

  // Search starts one past the previous grant so every pending channel gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      search_idx = CH_W'((int'(last_grant_reg) + k) % NUM_CH);
      if (!grant_found && pending_reg[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    pending_next    = pending_reg;
    last_grant_next = last_grant_reg;
    issue_flag_next = 1'b0;
    issue_data_next = issue_data_reg;
    cnt_next        = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          issue_data_next         = {grant_idx, data_buf_reg[grant_idx]};
          issue_flag_next         = 1'b1;
          pending_next[grant_idx] = 1'b0;
          last_grant_next         = grant_idx;
          state_next              = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CNT_W'(HOLDOFF - 1);
        state_next = HOLD;
      end
      HOLD: begin
        if (cnt_reg == '0) state_next = IDLE;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
    // A capture on the granted channel re-arms it, so it is OR-ed in last.
    pending_next = pending_next | REQ_FLAG;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      last_grant_reg <= CH_W'(NUM_CH - 1);
      issue_flag_reg <= 1'b0;
      issue_data_reg <= '0;
      cnt_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      last_grant_reg <= last_grant_next;
      issue_flag_reg <= issue_flag_next;
      issue_data_reg <= issue_data_next;
      cnt_reg        <= cnt_next;
    end
  end

`ifdef CDC_ARB_OVERRUN_EN
  logic [NUM_CH-1:0] overrun_reg, overrun_next;
  logic [NUM_CH-1:0] granted_mask;

  always_comb begin
    granted_mask = '0;
    if (state_reg == IDLE && grant_found) granted_mask[grant_idx] = 1'b1;
    overrun_next = (REQ_FLAG & pending_reg & ~granted_mask)
                 | (OVERRUN_CLR ? '0 : overrun_reg);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) overrun_reg <= '0;
    else          overrun_reg <= overrun_next;
  end

  assign OVERRUN = overrun_reg;
`endif

  assign ISSUE_FLAG = issue_flag_reg;
  assign ISSUE_DATA = issue_data_reg;
  assign PENDING    = pending_reg;
  assign BUSY       = (state_reg != IDLE);

endmodule

// File: tb/tb_cdc_channel_arbiter.sv
// Directed bench for cdc_channel_arbiter (NUM_CH=4, DATA_WIDTH=12, HOLDOFF=8); overrun checks under CDC_ARB_OVERRUN_EN.
module tb_cdc_channel_arbiter;

  logic        CLK;
  logic        RESET_N;
  logic [3:0]  REQ_FLAG;
  logic [47:0] REQ_DATA;
  logic        ISSUE_FLAG;
  logic [13:0] ISSUE_DATA;
  logic [3:0]  PENDING;
  logic        BUSY;
`ifdef CDC_ARB_OVERRUN_EN
  logic        OVERRUN_CLR;
  logic [3:0]  OVERRUN;
`endif

  int total = 0;
  int bad   = 0;

  cdc_channel_arbiter #(.NUM_CH(4), .DATA_WIDTH(12), .HOLDOFF(8)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .REQ_FLAG   (REQ_FLAG),
    .REQ_DATA   (REQ_DATA),
`ifdef CDC_ARB_OVERRUN_EN
    .OVERRUN_CLR(OVERRUN_CLR),
    .OVERRUN    (OVERRUN),
`endif
    .ISSUE_FLAG (ISSUE_FLAG),
    .ISSUE_DATA (ISSUE_DATA),
    .PENDING    (PENDING),
    .BUSY       (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic strobe(input int ch, input logic [11:0] d);
    REQ_FLAG = '0;
    REQ_FLAG[ch] = 1'b1;
    REQ_DATA[ch*12 +: 12] = d;
    tick();
    REQ_FLAG = '0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic wait_pulse(input string tag, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      tick();
      if (ISSUE_FLAG === 1'b1) begin
        seen = 1'b1;
        n = i;
      end
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 20 && BUSY === 1'b1; i++) tick();
    chk({tag, "_idle"}, 32'(BUSY), 32'd0);
  endtask

  int          n;
  int          busy_cnt;
  int          flag_cnt;
  int          np;
  int          unstable;
  int          pt [8];
  logic [13:0] pd [8];
  logic [13:0] prev;

  initial begin
    RESET_N  = 1'b0;
    REQ_FLAG = '0;
    REQ_DATA = '0;
`ifdef CDC_ARB_OVERRUN_EN
    OVERRUN_CLR = 1'b0;
`endif
    tick();
    tick();
    chk("rst_flag", 32'(ISSUE_FLAG), 32'd0);
    chk("rst_data", 32'(ISSUE_DATA), 32'd0);
    chk("rst_pend", 32'(PENDING), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
`ifdef CDC_ARB_OVERRUN_EN
    chk("rst_ovr", 32'(OVERRUN), 32'd0);
`endif
    RESET_N = 1'b1;
    repeat (3) tick();

    // Single request: 2-cycle latency, 9 busy cycles.
    strobe(2, 12'hABC);
    chk("t1_pend_cap", 32'(PENDING), 32'h4);
    chk("t1_flag_cap", 32'(ISSUE_FLAG), 32'd0);
    tick();
    chk("t1_flag", 32'(ISSUE_FLAG), 32'd1);
    chk("t1_data", 32'(ISSUE_DATA), 32'h2ABC);
    chk("t1_pend", 32'(PENDING), 32'd0);
    busy_cnt = 1;
    flag_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (BUSY !== 1'b1) break;
      busy_cnt++;
      if (ISSUE_FLAG === 1'b1) flag_cnt++;
    end
    chk("t1_busy_len", 32'(busy_cnt), 32'd9);
    chk("t1_flag_len", 32'(flag_cnt), 32'd1);
    chk("t1_data_hold", 32'(ISSUE_DATA), 32'h2ABC);
    chk("t1_flag_idle", 32'(ISSUE_FLAG), 32'd0);

    // All channels at once after reset: ch0..ch3 in order, 10 cycles apart.
    do_reset();
    REQ_FLAG = 4'hF;
    REQ_DATA = {12'd4, 12'd3, 12'd2, 12'd1};
    tick();
    REQ_FLAG = '0;
    np = 0;
    unstable = 0;
    prev = ISSUE_DATA;
    for (int c = 1; c <= 42; c++) begin
      tick();
      if (ISSUE_FLAG === 1'b1) begin
        if (np < 8) begin
          pt[np] = c;
          pd[np] = ISSUE_DATA;
        end
        np++;
      end else if (ISSUE_DATA !== prev) begin
        unstable++;
      end
      prev = ISSUE_DATA;
    end
    chk("t2_npulse", 32'(np), 32'd4);
    chk("t2_first_at", 32'(pt[0]), 32'd1);
    chk("t2_d0", 32'(pd[0]), 32'h0001);
    chk("t2_d1", 32'(pd[1]), 32'h1002);
    chk("t2_d2", 32'(pd[2]), 32'h2003);
    chk("t2_d3", 32'(pd[3]), 32'h3004);
    chk("t2_gap01", 32'(pt[1] - pt[0]), 32'd10);
    chk("t2_gap12", 32'(pt[2] - pt[1]), 32'd10);
    chk("t2_gap23", 32'(pt[3] - pt[2]), 32'd10);
    chk("t2_stable", 32'(unstable), 32'd0);
    chk("t2_busy_end", 32'(BUSY), 32'd0);

    // ch1 overwritten during HOLD: only the newest value is issued.
    strobe(0, 12'h011);
    tick();
    chk("t3_ch0_data", 32'(ISSUE_DATA), 32'h0011);
    tick();
    strobe(1, 12'h100);
    strobe(1, 12'h200);
`ifdef CDC_ARB_OVERRUN_EN
    chk("t3_ovr_set", 32'(OVERRUN), 32'h2);
`endif
    wait_pulse("t3_ch1", n);
    chk("t3_ch1_data", 32'(ISSUE_DATA), 32'h1200);
    chk("t3_pend", 32'(PENDING), 32'd0);
    flag_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (ISSUE_FLAG === 1'b1) flag_cnt++;
    end
    chk("t3_no_repeat", 32'(flag_cnt), 32'd0);
`ifdef CDC_ARB_OVERRUN_EN
    chk("t3_ovr_sticky", 32'(OVERRUN), 32'h2);
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    chk("t3_ovr_clr", 32'(OVERRUN), 32'd0);
`endif

    // Capture on the grant edge: old value issued, channel stays pending.
    REQ_FLAG = 4'b0001;
    REQ_DATA[11:0] = 12'h011;
    tick();
    REQ_DATA[11:0] = 12'h055;
    tick();
    REQ_FLAG = '0;
    chk("t4_flag", 32'(ISSUE_FLAG), 32'd1);
    chk("t4_old_data", 32'(ISSUE_DATA), 32'h0011);
    chk("t4_pend", 32'(PENDING), 32'h1);
`ifdef CDC_ARB_OVERRUN_EN
    chk("t4_no_ovr", 32'(OVERRUN), 32'd0);
`endif
    wait_pulse("t4_second", n);
    chk("t4_gap", 32'(n), 32'd10);
    chk("t4_new_data", 32'(ISSUE_DATA), 32'h0055);
    chk("t4_pend_clr", 32'(PENDING), 32'd0);
    wait_idle("t4");

    // Fairness: ch3 requests every cycle, ch0 once; ch0 wins the next grant.
    REQ_FLAG = 4'b1000;
    REQ_DATA[47:36] = 12'h333;
    tick();
    tick();
    chk("t5_ch3_first", 32'(ISSUE_DATA), 32'h3333);
    tick();
    REQ_FLAG = 4'b1001;
    REQ_DATA[11:0] = 12'h0C0;
    tick();
    REQ_FLAG = 4'b1000;
    wait_pulse("t5_g1", n);
    chk("t5_ch0_granted", 32'(ISSUE_DATA), 32'h00C0);
    wait_pulse("t5_g2", n);
    chk("t5_ch3_again", 32'(ISSUE_DATA), 32'h3333);
    REQ_FLAG = '0;

    // Asynchronous reset mid-HOLD discards the pending ch2 request.
    do_reset();
    strobe(0, 12'h0AA);
    tick();
    tick();
    strobe(2, 12'h222);
    tick();
    chk("t6_pre_data", 32'(ISSUE_DATA), 32'h00AA);
    chk("t6_pre_pend", 32'(PENDING), 32'h4);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t6_rst_flag", 32'(ISSUE_FLAG), 32'd0);
    chk("t6_rst_data", 32'(ISSUE_DATA), 32'd0);
    chk("t6_rst_pend", 32'(PENDING), 32'd0);
    chk("t6_rst_busy", 32'(BUSY), 32'd0);
    tick();
    RESET_N = 1'b1;
    flag_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (ISSUE_FLAG === 1'b1 || BUSY === 1'b1) flag_cnt++;
    end
    chk("t6_quiet", 32'(flag_cnt), 32'd0);
    strobe(1, 12'h5A5);
    tick();
    chk("t6_new_flag", 32'(ISSUE_FLAG), 32'd1);
    chk("t6_new_data", 32'(ISSUE_DATA), 32'h15A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
